demorgan_sweep_checker: RTL and testbench



---
 rtl/demorgan_pkg.sv | 24 ++
 rtl/demorgan_sweep_checker_if.sv | 34 +++
 rtl/demorgan_pair.sv | 91 +++++++++
 rtl/demorgan_sweep_checker.sv | 139 +++++++++++++
 tb/tb_demorgan_sweep_checker.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/demorgan_pkg.sv
// Shared types for the De Morgan sweep checker: identity selector and
// controller state encoding.
package demorgan_pkg;

  // Which identity pair is exercised during a sweep
  typedef enum logic [1:0] {
    MODE_NAND_NEGOR  = 2'd0,
    MODE_NOR_NEGAND  = 2'd1,
    MODE_AND_VIA_NOR = 2'd2,
    MODE_OR_VIA_NAND = 2'd3
  } mode_e;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Supported gate widths
  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 8;

endpackage

// File: rtl/demorgan_sweep_checker_if.sv
// Control/result bundle of the De Morgan sweep checker. The master side
// requests sweeps and reads results; the slave side is the checker itself.
interface demorgan_sweep_checker_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic [1:0]      mode;
  logic            fault_en;
  logic [N_IN-1:0] fault_vec;

  logic            busy;
  logic            done;
  logic [N_IN-1:0] vec;
  logic            ref_bit;
  logic            dut_bit;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err_vec;
  logic            first_err_valid;

  modport master (
    output start, mode, fault_en, fault_vec,
    input  busy, done, vec, ref_bit, dut_bit, pass, err_count,
           first_err_vec, first_err_valid
  );

  modport slave (
    input  start, mode, fault_en, fault_vec,
    output busy, done, vec, ref_bit, dut_bit, pass, err_count,
           first_err_vec, first_err_valid
  );

endinterface

// File: rtl/demorgan_pair.sv
// Combinational gate pair under test. Each identity is built from chains of
// two-input gate primitives so the structural form is genuinely gate-level;
// the mode only selects which already-built pair is presented.
module demorgan_pair
  import demorgan_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] v,
  input  mode_e           mode,
  output logic            ref_bit,
  output logic            raw_bit
);

  // Per-bit leaves plus running reductions; bit i of each chain combines
  // the previous stage with input i, so the last stage is the full reduction.
  for (genvar i = 0; i < N_IN; i++) begin : g_leaf
    wire inv_v;
    wire nor_self;
    wire nand_self;
    wire and_acc;
    wire or_acc;
    wire and_inv_acc;
    wire or_inv_acc;
    wire or_nor_acc;
    wire and_nand_acc;

    not  u_inv       (inv_v, v[i]);
    nor  u_nor_self  (nor_self, v[i], v[i]);
    nand u_nand_self (nand_self, v[i], v[i]);

    if (i == 0) begin : g_head
      buf u_and      (and_acc, v[i]);
      buf u_or       (or_acc, v[i]);
      buf u_and_inv  (and_inv_acc, inv_v);
      buf u_or_inv   (or_inv_acc, inv_v);
      buf u_or_nor   (or_nor_acc, nor_self);
      buf u_and_nand (and_nand_acc, nand_self);
    end else begin : g_link
      and u_and      (and_acc, g_leaf[i-1].and_acc, v[i]);
      or  u_or       (or_acc, g_leaf[i-1].or_acc, v[i]);
      and u_and_inv  (and_inv_acc, g_leaf[i-1].and_inv_acc, inv_v);
      or  u_or_inv   (or_inv_acc, g_leaf[i-1].or_inv_acc, inv_v);
      or  u_or_nor   (or_nor_acc, g_leaf[i-1].or_nor_acc, nor_self);
      and u_and_nand (and_nand_acc, g_leaf[i-1].and_nand_acc, nand_self);
    end
  end

  wire and_all   = g_leaf[N_IN-1].and_acc;
  wire or_all    = g_leaf[N_IN-1].or_acc;
  wire and_inv   = g_leaf[N_IN-1].and_inv_acc;
  wire or_inv    = g_leaf[N_IN-1].or_inv_acc;
  wire nand_all;
  wire nor_all;
  wire nor_of_nors;
  wire nand_of_nands;

  not u_nand_all (nand_all, and_all);
  not u_nor_all  (nor_all, or_all);
  not u_nor_top  (nor_of_nors, g_leaf[N_IN-1].or_nor_acc);
  not u_nand_top (nand_of_nands, g_leaf[N_IN-1].and_nand_acc);

  // Present the direct-form and structural-form outputs of the selected identity
  always_comb begin
    ref_bit = 1'b0;
    raw_bit = 1'b0;
    case (mode)
      MODE_NAND_NEGOR: begin
        ref_bit = nand_all;
        raw_bit = or_inv;
      end
      MODE_NOR_NEGAND: begin
        ref_bit = nor_all;
        raw_bit = and_inv;
      end
      MODE_AND_VIA_NOR: begin
        ref_bit = and_all;
        raw_bit = nor_of_nors;
      end
      MODE_OR_VIA_NAND: begin
        ref_bit = or_all;
        raw_bit = nand_of_nands;
      end
      default: begin
        ref_bit = 1'b0;
        raw_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Self-running exhaustive equivalence checker. A start request latches the
// configuration, every input vector is applied once to the gate pair and
// compared, then a one-cycle done pulse marks the results as valid.
module demorgan_sweep_checker
  import demorgan_pkg::*;
#(
  parameter int N_IN = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  demorgan_sweep_checker_if.slave bus
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_e          state_q;
  state_e          state_d;
  mode_e           mode_q;
  logic            fault_en_q;
  logic [N_IN-1:0] fault_vec_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN:0]   err_count_q;
  logic [N_IN-1:0] first_err_vec_q;
  logic            first_err_valid_q;
  logic            pass_q;
  logic            done_q;

  logic            accept;
  logic            step;
  logic            finish;
  logic            busy;
  logic            ref_bit;
  logic            raw_bit;
  logic            fault_hit;
  logic            dut_bit;
  logic            mismatch;

  demorgan_pair #(.N_IN(N_IN)) u_pair (
    .v       (vec_q),
    .mode    (mode_q),
    .ref_bit (ref_bit),
    .raw_bit (raw_bit)
  );

  assign busy      = (state_q != ST_IDLE);
  assign fault_hit = fault_en_q && busy && (vec_q == fault_vec_q);
  assign dut_bit   = raw_bit ^ fault_hit;
  assign mismatch  = ref_bit ^ dut_bit;

  // State register; reset aborts any sweep in progress without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state datapath strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        step = 1'b1;
        if (vec_q == LAST_VEC) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Configuration latch, vector counter, error tally and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q            <= MODE_NAND_NEGOR;
      fault_en_q        <= 1'b0;
      fault_vec_q       <= '0;
      vec_q             <= '0;
      err_count_q       <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
      pass_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mode_q            <= mode_e'(bus.mode);
        fault_en_q        <= bus.fault_en;
        fault_vec_q       <= bus.fault_vec;
        vec_q             <= '0;
        err_count_q       <= '0;
        first_err_vec_q   <= '0;
        first_err_valid_q <= 1'b0;
        pass_q            <= 1'b0;
      end
      if (step) begin
        if (mismatch) begin
          err_count_q <= err_count_q + (N_IN+1)'(1);
          if (!first_err_valid_q) begin
            first_err_vec_q   <= vec_q;
            first_err_valid_q <= 1'b1;
          end
        end
        vec_q <= vec_q + N_IN'(1);
      end
      if (finish) begin
        done_q <= 1'b1;
        pass_q <= (err_count_q == '0);
      end
    end
  end

  assign bus.busy            = busy;
  assign bus.done            = done_q;
  assign bus.vec             = vec_q;
  assign bus.ref_bit         = ref_bit;
  assign bus.dut_bit         = dut_bit;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_vec   = first_err_vec_q;
  assign bus.first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for the De Morgan sweep checker: three instances (N_IN = 2, 3, 8)
// driven from a table of directed sweeps plus hand-written sequences for
// back-to-back restart and mid-sweep reset.
module tb_demorgan_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       start_s [3];
  logic [1:0] mode_s  [3];
  logic       fen_s   [3];
  logic [7:0] fvec_s  [3];

  demorgan_sweep_checker_if #(.N_IN(2)) if2 ();
  demorgan_sweep_checker_if #(.N_IN(3)) if3 ();
  demorgan_sweep_checker_if #(.N_IN(8)) if8 ();

  assign if2.start = start_s[0];
  assign if2.mode = mode_s[0];
  assign if2.fault_en = fen_s[0];
  assign if2.fault_vec = fvec_s[0][1:0];
  assign if3.start = start_s[1];
  assign if3.mode = mode_s[1];
  assign if3.fault_en = fen_s[1];
  assign if3.fault_vec = fvec_s[1][2:0];
  assign if8.start = start_s[2];
  assign if8.mode = mode_s[2];
  assign if8.fault_en = fen_s[2];
  assign if8.fault_vec = fvec_s[2];

  demorgan_sweep_checker #(.N_IN(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  demorgan_sweep_checker #(.N_IN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  demorgan_sweep_checker #(.N_IN(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  logic       done_o [3];
  logic       busy_o [3];
  logic       pass_o [3];
  logic       fval_o [3];
  logic       ref_o  [3];
  logic       dut_o  [3];
  logic [8:0] err_o  [3];
  logic [7:0] vec_o  [3];
  logic [7:0] fev_o  [3];

  // Gather the three instances' outputs into common arrays
  always_comb begin
    done_o[0] = if2.done;  busy_o[0] = if2.busy;  pass_o[0] = if2.pass;
    fval_o[0] = if2.first_err_valid;  ref_o[0] = if2.ref_bit;  dut_o[0] = if2.dut_bit;
    err_o[0] = 9'(if2.err_count);  vec_o[0] = 8'(if2.vec);  fev_o[0] = 8'(if2.first_err_vec);
    done_o[1] = if3.done;  busy_o[1] = if3.busy;  pass_o[1] = if3.pass;
    fval_o[1] = if3.first_err_valid;  ref_o[1] = if3.ref_bit;  dut_o[1] = if3.dut_bit;
    err_o[1] = 9'(if3.err_count);  vec_o[1] = 8'(if3.vec);  fev_o[1] = 8'(if3.first_err_vec);
    done_o[2] = if8.done;  busy_o[2] = if8.busy;  pass_o[2] = if8.pass;
    fval_o[2] = if8.first_err_valid;  ref_o[2] = if8.ref_bit;  dut_o[2] = if8.dut_bit;
    err_o[2] = 9'(if8.err_count);  vec_o[2] = 8'(if8.vec);  fev_o[2] = 8'(if8.first_err_vec);
  end

  typedef struct {
    int         inst;
    logic [1:0] mode;
    logic       fen;
    logic [7:0] fvec;
    logic       exp_pass;
    int         exp_err;
    logic       exp_fval;
    logic [7:0] exp_fvec;
  } vec_t;

  vec_t table_v [7];
  int   compared = 0;
  int   mismatched = 0;

  function automatic int inst_width(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 8);
  endfunction

  // Direct behavioural evaluation of the reference form of each identity
  function automatic logic ref_model(input logic [1:0] m, input logic [7:0] v, input int n);
    logic a;
    logic o;
    a = 1'b1;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a & v[i];
      o = o | v[i];
    end
    case (m)
      2'd0:    return ~a;
      2'd1:    return ~o;
      2'd2:    return a;
      default: return o;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetState(input int idx);
    checkOutput("rst_busy", 32'(busy_o[idx]), 0);
    checkOutput("rst_done", 32'(done_o[idx]), 0);
    checkOutput("rst_vec", 32'(vec_o[idx]), 0);
    checkOutput("rst_pass", 32'(pass_o[idx]), 0);
    checkOutput("rst_err", 32'(err_o[idx]), 0);
    checkOutput("rst_fev", 32'(fev_o[idx]), 0);
    checkOutput("rst_fval", 32'(fval_o[idx]), 0);
    checkOutput("rst_ref", 32'(ref_o[idx]), 1);
    checkOutput("rst_dut", 32'(dut_o[idx]), 1);
  endtask

  // Wait (bounded) for done on one instance; returns cycles waited or -1
  task automatic waitDone(input int idx, input int budget, output int waited);
    waited = -1;
    for (int j = 0; j <= budget; j++) begin
      if (done_o[idx]) begin
        waited = j;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Launch one sweep, scramble the inputs while busy, check every applied vector
  task automatic applyStimulus(input vec_t r, output int latency);
    int idx;
    int n;
    int w;
    logic er;
    idx = r.inst;
    n = inst_width(idx);
    @(negedge clk);
    mode_s[idx] = r.mode;
    fen_s[idx] = r.fen;
    fvec_s[idx] = r.fvec;
    start_s[idx] = 1'b1;
    @(posedge clk); #1;
    start_s[idx] = 1'b0;
    mode_s[idx] = ~r.mode;
    fen_s[idx] = ~r.fen;
    fvec_s[idx] = ~r.fvec;
    checkOutput("sweep_busy", 32'(busy_o[idx]), 1);
    for (int k = 0; k < (1 << n); k++) begin
      er = ref_model(r.mode, 8'(k), n);
      checkOutput("sweep_vec", 32'(vec_o[idx]), 32'(k));
      checkOutput("sweep_ref", 32'(ref_o[idx]), 32'(er));
      checkOutput("sweep_dut", 32'(dut_o[idx]), 32'(er ^ (r.fen && (8'(k) == r.fvec))));
      @(posedge clk); #1;
    end
    waitDone(idx, 4, w);
    latency = (w < 0) ? -1 : (1 << n) + w;
  endtask

  initial begin
    int lat;
    int w;
    int n;

    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      mode_s[i] = 2'd0;
      fen_s[i] = 1'b0;
      fvec_s[i] = 8'h00;
    end
    rst_n = 1'b0;

    table_v[0] = '{0, 2'd0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    table_v[1] = '{1, 2'd1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    table_v[2] = '{1, 2'd2, 1'b1, 8'h05, 1'b0, 1, 1'b1, 8'h05};
    table_v[3] = '{2, 2'd3, 1'b1, 8'hFF, 1'b0, 1, 1'b1, 8'hFF};
    table_v[4] = '{0, 2'd2, 1'b1, 8'h00, 1'b0, 1, 1'b1, 8'h00};
    table_v[5] = '{1, 2'd0, 1'b0, 8'h03, 1'b1, 0, 1'b0, 8'h00};
    table_v[6] = '{0, 2'd1, 1'b1, 8'h03, 1'b0, 1, 1'b1, 8'h03};

    #12;
    $display("[TB] checking reset state");
    for (int i = 0; i < 3; i++) checkResetState(i);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      n = inst_width(table_v[t].inst);
      $display("[TB] vector %0d: N_IN=%0d mode=%0d", t, n, table_v[t].mode);
      applyStimulus(table_v[t], lat);
      checkOutput("latency", 32'(lat), 32'((1 << n) + 1));
      checkOutput("pass", 32'(pass_o[table_v[t].inst]), 32'(table_v[t].exp_pass));
      checkOutput("err_count", 32'(err_o[table_v[t].inst]), 32'(table_v[t].exp_err));
      checkOutput("first_err_valid", 32'(fval_o[table_v[t].inst]), 32'(table_v[t].exp_fval));
      checkOutput("first_err_vec", 32'(fev_o[table_v[t].inst]), 32'(table_v[t].exp_fvec));
      checkOutput("busy_at_done", 32'(busy_o[table_v[t].inst]), 0);
      @(posedge clk); #1;
      checkOutput("done_one_cycle", 32'(done_o[table_v[t].inst]), 0);
      checkOutput("err_held", 32'(err_o[table_v[t].inst]), 32'(table_v[t].exp_err));
      checkOutput("pass_held", 32'(pass_o[table_v[t].inst]), 32'(table_v[t].exp_pass));
    end

    // Start held high: mode change mid-sweep ignored, then immediate restart
    $display("[TB] back-to-back sweeps on N_IN=2");
    @(negedge clk);
    mode_s[0] = 2'd3;
    fen_s[0] = 1'b0;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    checkOutput("b2b_ref_v0_mode3", 32'(ref_o[0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mode_s[0] = 2'd0;
    @(posedge clk); #1;
    checkOutput("b2b_vec3", 32'(vec_o[0]), 3);
    checkOutput("b2b_ref_v3_mode3", 32'(ref_o[0]), 1);
    waitDone(0, 4, w);
    checkOutput("b2b_first_done_wait", 32'(w), 2);
    checkOutput("b2b_first_pass", 32'(pass_o[0]), 1);
    @(posedge clk); #1;
    checkOutput("b2b_restart_busy", 32'(busy_o[0]), 1);
    checkOutput("b2b_restart_done", 32'(done_o[0]), 0);
    checkOutput("b2b_restart_vec", 32'(vec_o[0]), 0);
    checkOutput("b2b_ref_v0_mode0", 32'(ref_o[0]), 1);
    start_s[0] = 1'b0;
    waitDone(0, 10, w);
    checkOutput("b2b_second_done_wait", 32'(w), 5);
    checkOutput("b2b_second_pass", 32'(pass_o[0]), 1);
    checkOutput("b2b_second_err", 32'(err_o[0]), 0);

    // Asynchronous reset in the middle of a sweep
    $display("[TB] mid-sweep reset on N_IN=3");
    @(negedge clk);
    mode_s[1] = 2'd1;
    fen_s[1] = 1'b1;
    fvec_s[1] = 8'h02;
    start_s[1] = 1'b1;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_vec4", 32'(vec_o[1]), 4);
    checkOutput("mid_err_before_reset", 32'(err_o[1]), 1);
    checkOutput("mid_fev_before_reset", 32'(fev_o[1]), 2);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState(1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checkOutput("mid_no_done", 32'(done_o[1]), 0);
      checkOutput("mid_idle", 32'(busy_o[1]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(table_v[1], lat);
    checkOutput("mid_fresh_latency", 32'(lat), 9);
    checkOutput("mid_fresh_pass", 32'(pass_o[1]), 1);
    checkOutput("mid_fresh_err", 32'(err_o[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
